// File: rtl/ltc5548_spi_sequencer.sv
// ============================================================================
// Module   : ltc5548_spi_sequencer
// Purpose  : Runs one two-byte LTC5548 register frame through a memory-mapped
//            SPI-master core. Every frame clears the master status, asserts
//            slave select, and then sends each byte. After each byte it polls
//            RRDY and drains the receive register. Finally it releases slave
//            select and reports the result. If RRDY never comes, the poll
//            timeout aborts the frame, releases slave select and flags the
//            error.
// Ports    : clk, reset_n (async, active-low)
//            cmd_valid/cmd_ready/cmd_rd/cmd_addr/cmd_wdata : command handshake
//            rsp_valid/rsp_rdata/rsp_err                   : response pulse
//            busy                                          : frame in progress
//            spi_select/spi_read_n/spi_write_n/spi_mem_addr/
//            spi_data_from_cpu/spi_data_to_cpu             : SPI-master bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltc5548_spi_sequencer #(
   parameter int unsigned TIMEOUT_POLLS = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic [6:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        spi_select,
   output logic        spi_read_n,
   output logic        spi_write_n,
   output logic [2:0]  spi_mem_addr,
   output logic [15:0] spi_data_from_cpu,
   input  logic [15:0] spi_data_to_cpu
);

   localparam logic [2:0] ADDR_RX   = 3'd0;
   localparam logic [2:0] ADDR_TX   = 3'd1;
   localparam logic [2:0] ADDR_STAT = 3'd2;
   localparam logic [2:0] ADDR_CTRL = 3'd3;
   localparam logic [9:0] TIMEOUT   = 10'(TIMEOUT_POLLS);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR_STAT, S_SSO_ON, S_TX, S_POLL, S_RX, S_SSO_OFF, S_RESP
   } state_t;

   // Every bus state runs A1, A2, then one idle gap cycle.
   typedef enum logic [1:0] {PH_A1, PH_A2, PH_GAP} phase_t;

   state_t      state_q, state_d;
   phase_t      phase_q;
   logic        launch_d, timeout_d;
   logic        acc_rd_d;
   logic [2:0]  acc_addr_d;
   logic [15:0] acc_data_d;
   logic [7:0]  tx_byte_d;
   logic        bus_state_d;

   logic        rd_q, byte2_q, rrdy_q, err_q;
   logic [6:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [9:0]  poll_cnt_q;

   logic        cmd_ready_q, busy_q, rsp_valid_q, rsp_err_q;
   logic [7:0]  rsp_rdata_q;
   logic        sel_q, rd_n_q, wr_n_q;
   logic [2:0]  maddr_q;
   logic [15:0] mdata_q;

   // Only the low byte of the master read data carries anything of interest.
   logic unused_data_hi;
   assign unused_data_hi = &{1'b0, spi_data_to_cpu[15:8]};

   // Next-state and next-access decode; accesses launch only from IDLE or
   // from the gap cycle, so the idle cycle between accesses is guaranteed.
   always_comb begin
      state_d     = state_q;
      launch_d    = 1'b0;
      timeout_d   = 1'b0;
      acc_rd_d    = 1'b0;
      acc_addr_d  = 3'd0;
      acc_data_d  = 16'h0000;
      bus_state_d = (state_q != S_IDLE) && (state_q != S_RESP);
      // Byte2 is sent when leaving RX; byte1 when leaving SSO_ON.
      tx_byte_d   = (state_q == S_RX) ? (rd_q ? 8'h00 : wdata_q) : {rd_q, addr_q};

      case (state_q)
         S_IDLE:     if (cmd_valid) begin state_d = S_CLR_STAT; launch_d = 1'b1; end
         S_CLR_STAT: if (phase_q == PH_GAP) begin state_d = S_SSO_ON; launch_d = 1'b1; end
         S_SSO_ON:   if (phase_q == PH_GAP) begin state_d = S_TX; launch_d = 1'b1; end
         S_TX:       if (phase_q == PH_GAP) begin state_d = S_POLL; launch_d = 1'b1; end
         S_POLL: begin
            if (phase_q == PH_GAP) begin
               launch_d = 1'b1;
               if (rrdy_q) begin
                  state_d = S_RX;
               end else if (poll_cnt_q >= TIMEOUT) begin
                  state_d   = S_SSO_OFF;
                  timeout_d = 1'b1;
               end else begin
                  state_d = S_POLL;
               end
            end
         end
         S_RX: begin
            if (phase_q == PH_GAP) begin
               launch_d = 1'b1;
               state_d  = byte2_q ? S_SSO_OFF : S_TX;
            end
         end
         S_SSO_OFF:  if (phase_q == PH_GAP) state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      case (state_d)
         S_CLR_STAT: acc_addr_d = ADDR_STAT;
         S_SSO_ON:   begin acc_addr_d = ADDR_CTRL; acc_data_d = 16'h0400; end
         S_TX:       begin acc_addr_d = ADDR_TX; acc_data_d = {8'h00, tx_byte_d}; end
         S_POLL:     begin acc_rd_d = 1'b1; acc_addr_d = ADDR_STAT; end
         S_RX:       begin acc_rd_d = 1'b1; acc_addr_d = ADDR_RX; end
         S_SSO_OFF:  acc_addr_d = ADDR_CTRL;
         default:    acc_addr_d = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_A1;
         rd_q        <= 1'b0;
         addr_q      <= 7'd0;
         wdata_q     <= 8'd0;
         byte2_q     <= 1'b0;
         rrdy_q      <= 1'b0;
         err_q       <= 1'b0;
         poll_cnt_q  <= 10'd0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 8'd0;
         sel_q       <= 1'b0;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         maddr_q     <= 3'd0;
         mdata_q     <= 16'h0000;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= 1'b0;

         if (launch_d) begin
            phase_q     <= PH_A1;
            sel_q       <= 1'b1;
            rd_n_q      <= ~acc_rd_d;
            wr_n_q      <= acc_rd_d;
            maddr_q     <= acc_addr_d;
            mdata_q     <= acc_data_d;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
         end else if (bus_state_d && phase_q == PH_A1) begin
            phase_q <= PH_A2;
         end else if (bus_state_d && phase_q == PH_A2) begin
            // Edge ending A2: sample read data and drop the bus to idle.
            phase_q <= PH_GAP;
            sel_q   <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            maddr_q <= 3'd0;
            mdata_q <= 16'h0000;
            if (state_q == S_POLL) begin
               rrdy_q     <= spi_data_to_cpu[7];
               poll_cnt_q <= poll_cnt_q + 10'd1;
            end
            if (state_q == S_RX && byte2_q) begin
               rsp_rdata_q <= spi_data_to_cpu[7:0];
            end
         end

         if (state_q == S_IDLE && cmd_valid) begin
            rd_q    <= cmd_rd;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            err_q   <= 1'b0;
            byte2_q <= 1'b0;
         end

         if (launch_d && state_d == S_TX) begin
            poll_cnt_q <= 10'd0;
            rrdy_q     <= 1'b0;
            if (state_q == S_RX) begin
               byte2_q <= 1'b1;
            end
         end

         if (timeout_d) begin
            err_q <= 1'b1;
         end

         if (state_q == S_SSO_OFF && state_d == S_RESP) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
         end

         if (state_q == S_RESP) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
         end
      end
   end

   assign cmd_ready         = cmd_ready_q;
   assign busy              = busy_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_err           = rsp_err_q;
   assign rsp_rdata         = rsp_rdata_q;
   assign spi_select        = sel_q;
   assign spi_read_n        = rd_n_q;
   assign spi_write_n       = wr_n_q;
   assign spi_mem_addr      = maddr_q;
   assign spi_data_from_cpu = mdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ltc5548_spi_sequencer.sv
// ============================================================================
// Module   : tb_ltc5548_spi_sequencer
// Purpose  : Directed self-checking bench for ltc5548_spi_sequencer. It
//            contains a small SPI-master model that returns RRDY on a chosen
//            poll and returns receive bytes. It also logs every bus access,
//            and checks access shape and idle-cycle values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ltc5548_spi_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_rd = 1'b0;
   logic [6:0]  cmd_addr = 7'd0;
   logic [7:0]  cmd_wdata = 8'd0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        spi_select;
   logic        spi_read_n;
   logic        spi_write_n;
   logic [2:0]  spi_mem_addr;
   logic [15:0] spi_data_from_cpu;
   logic [15:0] spi_data_to_cpu;

   always #5 clk = ~clk;

   ltc5548_spi_sequencer #(.TIMEOUT_POLLS(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_rd            (cmd_rd),
      .cmd_addr          (cmd_addr),
      .cmd_wdata         (cmd_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .busy              (busy),
      .spi_select        (spi_select),
      .spi_read_n        (spi_read_n),
      .spi_write_n       (spi_write_n),
      .spi_mem_addr      (spi_mem_addr),
      .spi_data_from_cpu (spi_data_from_cpu),
      .spi_data_to_cpu   (spi_data_to_cpu)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- SPI-master model ----------------
   int         rrdy_after = 1;   // RRDY on this poll after each byte (0 = never)
   logic [7:0] rx2 = 8'h00;      // byte returned for frame byte2
   int         poll_reads = 0;
   int         tx_count = 0;

   always_comb begin
      spi_data_to_cpu = 16'h0000;
      case (spi_mem_addr)
         3'd2: spi_data_to_cpu = (rrdy_after != 0 && poll_reads + 1 >= rrdy_after) ? 16'h00C0 : 16'h0040;
         3'd0: spi_data_to_cpu = (tx_count >= 2) ? {8'hC0, rx2} : 16'hC05A;
         default: spi_data_to_cpu = 16'h0000;
      endcase
   end

   // ---------------- bus monitor ----------------
   logic [19:0] log_q[$];
   logic [19:0] exp_q[$];
   int          run = 0;
   logic        cur_rn, cur_wn;
   logic [2:0]  cur_addr;
   logic [15:0] cur_data;

   function automatic logic [19:0] enc(input logic rd, input logic [2:0] a, input logic [15:0] d);
      return {rd, a, rd ? 16'h0000 : d};
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         run        = 0;
         poll_reads = 0;
         tx_count   = 0;
      end else if (spi_select) begin
         if (run == 0) begin
            cur_rn   = spi_read_n;
            cur_wn   = spi_write_n;
            cur_addr = spi_mem_addr;
            cur_data = spi_data_from_cpu;
            check("acc_strobe", 32'(spi_read_n ^ spi_write_n), 32'd1);
         end else begin
            check("acc_stable", {12'd0, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu},
                  {12'd0, cur_rn, cur_wn, cur_addr, cur_data});
         end
         run++;
      end else begin
         check("idle_bus", {10'd0, spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu},
               {10'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});
         if (run != 0) begin
            check("acc_len", run, 2);
            log_q.push_back(enc(!cur_rn, cur_addr, cur_data));
            if (!cur_rn && cur_addr == 3'd2) poll_reads++;
            if (!cur_wn && cur_addr == 3'd1) begin tx_count++; poll_reads = 0; end
            if (!cur_wn && cur_addr == 3'd3 && cur_data == 16'h0400) tx_count = 0;
            run = 0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic expect_frame(input logic [7:0] b1, input logic [7:0] b2,
                               input int p1, input int p2, input bit abort);
      exp_q.push_back(enc(1'b0, 3'd2, 16'h0000));
      exp_q.push_back(enc(1'b0, 3'd3, 16'h0400));
      exp_q.push_back(enc(1'b0, 3'd1, {8'h00, b1}));
      for (int i = 0; i < p1; i++) exp_q.push_back(enc(1'b1, 3'd2, 16'h0000));
      if (!abort) begin
         exp_q.push_back(enc(1'b1, 3'd0, 16'h0000));
         exp_q.push_back(enc(1'b0, 3'd1, {8'h00, b2}));
         for (int i = 0; i < p2; i++) exp_q.push_back(enc(1'b1, 3'd2, 16'h0000));
         exp_q.push_back(enc(1'b1, 3'd0, 16'h0000));
      end
      exp_q.push_back(enc(1'b0, 3'd3, 16'h0000));
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check(tag, log_q[i], exp_q[i]);
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic send_cmd(input logic rd, input logic [6:0] a, input logic [7:0] d);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rd    = rd;
      cmd_addr  = a;
      cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 3000) begin @(negedge clk); k++; end
      if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic err, output logic [7:0] rdata, output int bad);
      bit got;
      got   = 0;
      bad   = 0;
      err   = 1'bx;
      rdata = 8'hxx;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got   = 1;
            err   = rsp_err;
            rdata = rsp_rdata;
         end else if (cmd_ready || !busy) begin
            bad++;
         end
      end
      if (!got) begin
         check("rsp_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);
         check("rsp_pulse", 32'(rsp_valid), 32'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   logic       r_err;
   logic [7:0] r_data;
   int         r_bad;
   int         snap;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctl", {24'd0, cmd_ready, busy, rsp_valid, rsp_err, 4'd0}, {24'd0, 4'b1000, 4'd0});
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_ready", {30'd0, cmd_ready, busy}, {30'd0, 2'b10});

      // Write 0x12 <- 0xA5, RRDY on the third poll of each byte.
      rrdy_after = 3; rx2 = 8'h11;
      send_cmd(1'b0, 7'h12, 8'hA5);
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'h12, 8'hA5, 3, 3, 1'b0);
      compare_log("wr_frame");
      check("wr_err", 32'(r_err), 32'd0);
      check("wr_rdata", 32'(r_data), 32'h11);
      check("wr_busy_ready", r_bad, 0);

      // Read 0x05, byte2 returns 0x3C.
      rrdy_after = 1; rx2 = 8'h3C;
      send_cmd(1'b1, 7'h05, 8'hFF);
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'h85, 8'h00, 1, 1, 1'b0);
      compare_log("rd_frame");
      check("rd_err", 32'(r_err), 32'd0);
      check("rd_rdata", 32'(r_data), 32'h3C);

      // RRDY on exactly the last allowed poll still completes.
      rrdy_after = 4; rx2 = 8'h5E;
      send_cmd(1'b0, 7'h33, 8'h00);
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'h33, 8'h00, 4, 4, 1'b0);
      compare_log("edge_frame");
      check("edge_err", 32'(r_err), 32'd0);
      check("edge_rdata", 32'(r_data), 32'h5E);

      // RRDY never arrives: four polls, release SS, error, rdata held.
      rrdy_after = 0; rx2 = 8'hAA;
      send_cmd(1'b1, 7'h05, 8'h00);
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'h85, 8'h00, 4, 0, 1'b1);
      compare_log("abort_frame");
      check("abort_err", 32'(r_err), 32'd1);
      check("abort_rdata", 32'(r_data), 32'h5E);
      check("abort_rdata_hold", 32'(rsp_rdata), 32'h5E);

      // cmd_valid held through a frame; second command waits for RESP.
      rrdy_after = 1; rx2 = 8'h99;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 7'h01; cmd_wdata = 8'h7E;
      @(posedge clk);
      #1 cmd_rd = 1'b1; cmd_addr = 7'h40; cmd_wdata = 8'h00;
      wait_rsp(r_err, r_data, r_bad);
      check("hold_a_err", 32'(r_err), 32'd0);
      check("hold_a_ready_low", r_bad, 0);
      check("hold_ready_after", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'h01, 8'h7E, 1, 1, 1'b0);
      expect_frame(8'hC0, 8'h00, 1, 1, 1'b0);
      compare_log("hold_frames");
      check("hold_b_rdata", 32'(r_data), 32'h99);

      // Reset pulsed during POLL.
      rrdy_after = 0;
      send_cmd(1'b0, 7'h22, 8'h44);
      begin
         int k;
         k = 0;
         while (!(spi_select && !spi_read_n && spi_mem_addr == 3'd2) && k < 3000) begin
            @(negedge clk); k++;
         end
         check("poll_seen", 32'(spi_select && !spi_read_n && spi_mem_addr == 3'd2), 32'd1);
      end
      #2 reset_n = 1'b0;
      #1;
      check("arst_ctl", {24'd0, cmd_ready, busy, rsp_valid, rsp_err, 4'd0}, {24'd0, 4'b1000, 4'd0});
      check("arst_rdata", 32'(rsp_rdata), 32'd0);
      check("arst_bus", {10'd0, spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu},
            {10'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});
      snap = log_q.size();
      repeat (3) @(negedge clk);
      check("arst_no_access", log_q.size(), snap);
      reset_n = 1'b1;
      log_q.delete();
      exp_q.delete();

      rrdy_after = 2; rx2 = 8'hC3;
      send_cmd(1'b1, 7'h7F, 8'h00);
      wait_rsp(r_err, r_data, r_bad);
      expect_frame(8'hFF, 8'h00, 2, 2, 1'b0);
      compare_log("post_rst_frame");
      check("post_rst_err", 32'(r_err), 32'd0);
      check("post_rst_rdata", 32'(r_data), 32'hC3);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
